expr_sweep_gen: RTL and testbench

Parametrised, synthesisable operand-sweep generator with a registered expression evaluator. It walks three operands through every combination in an odometer sweep, holds each vector for a programmable dwell, and evaluates one selectable Verilog operator per run, with an optional settle vector at the end. It sits in the diagnostic-regression harness as the stimulus and golden-result source for coverage-of-operator checks. It replaces hand-written nested-loop initial blocks.

---
 rtl/expr_sweep_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_expr_sweep_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_sweep_gen.sv
// expr_sweep_gen: odometer sweep of three operands (c fastest, a slowest),
// each vector held for DWELL cycles, with a registered evaluation of one
// selectable operator per run and an optional all-zero settle vector.
module expr_sweep_gen #(
    parameter int WIDTH     = 2,
    parameter int DWELL     = 5,
    parameter bit SETTLE_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4:0]           op_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 vec_valid,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [2*WIDTH-1:0]   result,
    output logic [3*WIDTH:0]     vec_count
);

    localparam int RW = 2 * WIDTH;
    localparam int OW = 3 * WIDTH;
    localparam int CW = 3 * WIDTH + 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1'b1);
    // Total vector count V = 2^(3*WIDTH): a single one above the operand bits.
    localparam logic [CW-1:0] VEC_TOTAL  = {1'b1, {OW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    logic [4:0]      op_r;
    logic [DW-1:0]   dwell_cnt_r;

    logic [OW-1:0]   operands_inc_s;
    logic [CW-1:0]   vec_count_inc_s;
    logic            dwell_end_s;
    logic            last_vec_s;
    logic [RW-1:0]   result_nxt_s;

    // Widen a single boolean to the result width.
    function automatic logic [RW-1:0] bool_ext(input logic bit_in);
        return {{(RW-1){1'b0}}, bit_in};
    endfunction

    // Reduction parity of one operand.
    function automatic logic parity(input logic [WIDTH-1:0] x);
        return ^x;
    endfunction

    // Operator evaluator: every result is zero-extended to 2*WIDTH bits.
    function automatic logic [RW-1:0] eval_op(
        input logic [4:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] z
    );
        logic [RW-1:0]    ex;
        logic [RW-1:0]    ey;
        logic [RW-1:0]    ez;
        logic [RW-1:0]    r;
        logic [WIDTH-1:0] zero_w;
        zero_w = {WIDTH{1'b0}};
        ex     = {zero_w, x};
        ey     = {zero_w, y};
        ez     = {zero_w, z};
        case (op)
            5'd0:    r = {RW{1'b0}};
            5'd1:    r = ex;
            5'd2:    r = ex ^ ey;
            5'd3:    r = ex & ey;
            5'd4:    r = ex | ey;
            5'd5:    r = {zero_w, x ~^ y};
            5'd6:    r = ex + ey;
            5'd7:    r = ex - ey;
            5'd8:    r = ex * ey;
            // Divide by zero returns all ones at operand width.
            5'd9:    r = (y == zero_w) ? {zero_w, {WIDTH{1'b1}}} : ex / ey;
            // Modulo by zero returns the dividend.
            5'd10:   r = (y == zero_w) ? ex : ex % ey;
            5'd11:   r = ex << y;
            5'd12:   r = ex >> y;
            5'd13:   r = bool_ext(x < y);
            5'd14:   r = bool_ext(x > y);
            5'd15:   r = bool_ext(x <= y);
            5'd16:   r = bool_ext(x >= y);
            5'd17:   r = bool_ext(x == y);
            5'd18:   r = bool_ext(x != y);
            5'd19:   r = bool_ext((x != zero_w) || (y != zero_w));
            5'd20:   r = bool_ext((x != zero_w) && (y != zero_w));
            5'd21:   r = (x != zero_w) ? ey : ez;
            5'd22:   r = {zero_w, ~x};
            5'd23:   r = bool_ext(&x);
            5'd24:   r = bool_ext(|x);
            5'd25:   r = bool_ext(parity(x));
            5'd26:   r = bool_ext(~&x);
            5'd27:   r = bool_ext(~|x);
            5'd28:   r = bool_ext(~parity(x));
            5'd29:   r = bool_ext(x == zero_w);
            5'd30:   r = {x, x};
            5'd31:   r = {x, y};
            default: r = {RW{1'b0}};
        endcase
        return r;
    endfunction

    // Next odometer position, saturating vector count, dwell/sweep end decodes and next result.
    always_comb begin
        operands_inc_s  = {a, b, c} + {{(OW-1){1'b0}}, 1'b1};
        vec_count_inc_s = (vec_count == VEC_TOTAL) ? vec_count
                                                   : vec_count + {{(CW-1){1'b0}}, 1'b1};
        dwell_end_s     = (dwell_cnt_r == DWELL_LAST);
        last_vec_s      = &{a, b, c};
        result_nxt_s    = eval_op(op_r, a, b, c);
    end

    // Sweep sequencer: state, latched operator, dwell counter and all sweep outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 5'd0;
            dwell_cnt_r <= {DW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            vec_valid   <= 1'b0;
            a           <= {WIDTH{1'b0}};
            b           <= {WIDTH{1'b0}};
            c           <= {WIDTH{1'b0}};
            vec_count   <= {CW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    vec_valid <= 1'b0;
                    // start wins over a simultaneous abort here.
                    if (start) begin
                        state_r     <= ST_RUN;
                        op_r        <= op_sel;
                        dwell_cnt_r <= {DW{1'b0}};
                        busy        <= 1'b1;
                        vec_valid   <= 1'b1;
                        a           <= {WIDTH{1'b0}};
                        b           <= {WIDTH{1'b0}};
                        c           <= {WIDTH{1'b0}};
                        vec_count   <= {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        vec_valid <= 1'b0;
                    end else if (dwell_end_s) begin
                        dwell_cnt_r <= {DW{1'b0}};
                        if (last_vec_s) begin
                            vec_valid <= 1'b0;
                            if (SETTLE_EN) begin
                                state_r <= ST_SETTLE;
                                a       <= {WIDTH{1'b0}};
                                b       <= {WIDTH{1'b0}};
                                c       <= {WIDTH{1'b0}};
                            end else begin
                                state_r <= ST_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            {a, b, c}  <= operands_inc_s;
                            vec_count  <= vec_count_inc_s;
                            vec_valid  <= 1'b1;
                        end
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + DWELL_ONE;
                        vec_valid   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    vec_valid <= 1'b0;
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (dwell_end_s) begin
                        state_r     <= ST_DONE;
                        dwell_cnt_r <= {DW{1'b0}};
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r + DWELL_ONE;
                    end
                end
                ST_DONE: begin
                    // start and abort are both ignored for this one cycle.
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    vec_valid <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    vec_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result register: follows the operands with one cycle of lag while a run is
    // in progress (including the DONE cycle) and holds once back in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= {RW{1'b0}};
        end else if (state_r != ST_IDLE) begin
            result <= result_nxt_s;
        end else begin
            result <= result;
        end
    end

endmodule

// File: tb/tb_expr_sweep_gen.sv
// Bench for expr_sweep_gen: three instances share one set of inputs and are
// checked every cycle against an arithmetic timeline model (cycles since start).
module tb_expr_sweep_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [4:0] op_sel;

    always #5 clk = ~clk;

    // Instance 0: WIDTH=2, DWELL=5, settle on.
    logic       busy0, done0, vv0;
    logic [1:0] a0, b0, c0;
    logic [3:0] res0;
    logic [6:0] vc0;
    // Instance 1: WIDTH=1, DWELL=5, settle on.
    logic       busy1, done1, vv1;
    logic [0:0] a1, b1, c1;
    logic [1:0] res1;
    logic [3:0] vc1;
    // Instance 2: WIDTH=1, DWELL=1, settle off.
    logic       busy2, done2, vv2;
    logic [0:0] a2, b2, c2;
    logic [1:0] res2;
    logic [3:0] vc2;

    expr_sweep_gen #(.WIDTH(2), .DWELL(5), .SETTLE_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
        .busy(busy0), .done(done0), .vec_valid(vv0), .a(a0), .b(b0), .c(c0),
        .result(res0), .vec_count(vc0));
    expr_sweep_gen #(.WIDTH(1), .DWELL(5), .SETTLE_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
        .busy(busy1), .done(done1), .vec_valid(vv1), .a(a1), .b(b1), .c(c1),
        .result(res1), .vec_count(vc1));
    expr_sweep_gen #(.WIDTH(1), .DWELL(1), .SETTLE_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
        .busy(busy2), .done(done2), .vec_valid(vv2), .a(a2), .b(b2), .c(c2),
        .result(res2), .vec_count(vc2));

    int checks = 0;
    int failures = 0;

    // Model per instance: active run with k = edges since the start edge,
    // or idle with held output values.
    int m_active [3];
    int m_k      [3];
    int m_op     [3];
    int m_prev   [3];
    int m_ia     [3];
    int m_ib     [3];
    int m_ic     [3];
    int m_ivc    [3];
    int m_ires   [3];

    function automatic int pw(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int pd(input int i);
        return (i == 2) ? 1 : 5;
    endfunction
    function automatic int ps(input int i);
        return (i == 2) ? 0 : 1;
    endfunction
    function automatic int nvec(input int i);
        return 1 << (3 * pw(i));
    endfunction
    function automatic int run_len(input int i);
        return nvec(i) * pd(i);
    endfunction
    function automatic int tot_len(input int i);
        return run_len(i) + ((ps(i) != 0) ? pd(i) : 0);
    endfunction

    function automatic int ref_op(input int op, input int x, input int y, input int z, input int w);
        int mask;
        int md;
        int r;
        mask = (1 << w) - 1;
        md   = 1 << (2 * w);
        case (op)
            0:  r = 0;
            1:  r = x;
            2:  r = x ^ y;
            3:  r = x & y;
            4:  r = x | y;
            5:  r = mask & ~(x ^ y);
            6:  r = x + y;
            7:  r = (x - y + md) % md;
            8:  r = x * y;
            9:  r = (y == 0) ? mask : x / y;
            10: r = (y == 0) ? x : x % y;
            11: r = (x << y) % md;
            12: r = x >> y;
            13: r = (x < y) ? 1 : 0;
            14: r = (x > y) ? 1 : 0;
            15: r = (x <= y) ? 1 : 0;
            16: r = (x >= y) ? 1 : 0;
            17: r = (x == y) ? 1 : 0;
            18: r = (x != y) ? 1 : 0;
            19: r = (x != 0 || y != 0) ? 1 : 0;
            20: r = (x != 0 && y != 0) ? 1 : 0;
            21: r = (x != 0) ? y : z;
            22: r = mask & ~x;
            23: r = (x == mask) ? 1 : 0;
            24: r = (x != 0) ? 1 : 0;
            25: r = $countones(x) % 2;
            26: r = (x != mask) ? 1 : 0;
            27: r = (x == 0) ? 1 : 0;
            28: r = 1 - ($countones(x) % 2);
            29: r = (x == 0) ? 1 : 0;
            30: r = x * (mask + 1) + x;
            31: r = x * (mask + 1) + y;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Operands k edges after the start edge of an uninterrupted run.
    function automatic void ops_at(input int i, input int k, output int oa, output int ob, output int oc);
        int w;
        int mask;
        int idx;
        w = pw(i);
        mask = (1 << w) - 1;
        if (k < run_len(i)) begin
            idx = k / pd(i);
            oa = (idx >> (2 * w)) & mask;
            ob = (idx >> w) & mask;
            oc = idx & mask;
        end else if (k < tot_len(i) || ps(i) != 0) begin
            oa = 0; ob = 0; oc = 0;
        end else begin
            oa = mask; ob = mask; oc = mask;
        end
    endfunction

    function automatic int vc_at(input int i, input int k);
        return (k < run_len(i)) ? (k / pd(i) + 1) : nvec(i);
    endfunction

    // Advance every model by one clock edge using the inputs seen at that edge.
    function automatic void model_edge();
        int oa, ob, oc;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_active[i] = 0; m_op[i] = 0;
                m_ia[i] = 0; m_ib[i] = 0; m_ic[i] = 0; m_ivc[i] = 0; m_ires[i] = 0;
            end else if (m_active[i] == 0) begin
                if (start) begin
                    m_active[i] = 1; m_k[i] = 0; m_op[i] = int'(op_sel); m_prev[i] = m_ires[i];
                end
            end else if (abort && m_k[i] < tot_len(i)) begin
                ops_at(i, m_k[i], oa, ob, oc);
                m_ia[i] = oa; m_ib[i] = ob; m_ic[i] = oc;
                m_ivc[i] = vc_at(i, m_k[i]);
                m_ires[i] = ref_op(m_op[i], oa, ob, oc, pw(i));
                m_active[i] = 0;
            end else begin
                m_k[i] = m_k[i] + 1;
                if (m_k[i] > tot_len(i)) begin
                    ops_at(i, tot_len(i), oa, ob, oc);
                    m_ia[i] = oa; m_ib[i] = ob; m_ic[i] = oc;
                    m_ivc[i] = nvec(i);
                    m_ires[i] = ref_op(m_op[i], oa, ob, oc, pw(i));
                    m_active[i] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input int dut, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d t=%0t got=%0d expected=%0d", tag, dut, $time, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int ea, eb, ec, evc, eres, ebusy, edone, evv, k, pa, pb, pc;
            logic [31:0] ga, gb, gc, gvc, gres, gbusy, gdone, gvv;
            k = m_k[i];
            if (m_active[i] != 0) begin
                ops_at(i, k, ea, eb, ec);
                ebusy = (k < tot_len(i)) ? 1 : 0;
                edone = (k == tot_len(i)) ? 1 : 0;
                evv   = (k < run_len(i) && (k % pd(i)) == 0) ? 1 : 0;
                evc   = vc_at(i, k);
                if (k == 0) begin
                    eres = m_prev[i];
                end else begin
                    ops_at(i, k - 1, pa, pb, pc);
                    eres = ref_op(m_op[i], pa, pb, pc, pw(i));
                end
            end else begin
                ea = m_ia[i]; eb = m_ib[i]; ec = m_ic[i];
                ebusy = 0; edone = 0; evv = 0;
                evc = m_ivc[i]; eres = m_ires[i];
            end
            case (i)
                0: begin
                    ga = 32'(a0); gb = 32'(b0); gc = 32'(c0); gvc = 32'(vc0); gres = 32'(res0);
                    gbusy = 32'(busy0); gdone = 32'(done0); gvv = 32'(vv0);
                end
                1: begin
                    ga = 32'(a1); gb = 32'(b1); gc = 32'(c1); gvc = 32'(vc1); gres = 32'(res1);
                    gbusy = 32'(busy1); gdone = 32'(done1); gvv = 32'(vv1);
                end
                default: begin
                    ga = 32'(a2); gb = 32'(b2); gc = 32'(c2); gvc = 32'(vc2); gres = 32'(res2);
                    gbusy = 32'(busy2); gdone = 32'(done2); gvv = 32'(vv2);
                end
            endcase
            chk("busy", i, gbusy, ebusy);
            chk("done", i, gdone, edone);
            chk("vec_valid", i, gvv, evv);
            chk("a", i, ga, ea);
            chk("b", i, gb, eb);
            chk("c", i, gc, ec);
            chk("vec_count", i, gvc, evc);
            chk("result", i, gres, eres);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Run n cycles, optionally sprinkling start pulses with a random op_sel early on.
    task automatic run_cycles(input int n, input bit pulses);
        for (int j = 0; j < n; j++) begin
            if (pulses && j < n - 30 && $urandom_range(0, 19) == 0) begin
                start = 1'b1;
                op_sel = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int m;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_sel = 5'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        abort = 1'b1;              // abort while idle is ignored
        tick();
        abort = 1'b0;

        // Operator sweep, one full run per code; some starts coincide with abort.
        for (int op = 0; op < 32; op++) begin
            op_sel = 5'(op);
            start = 1'b1;
            abort = ((op % 4) == 3) ? 1'b1 : 1'b0;
            tick();
            start = 1'b0;
            abort = 1'b0;
            run_cycles(330, 1'b1);
        end

        // Abort during vector 10 on the WIDTH=2 instance, then restart.
        op_sel = 5'($urandom_range(0, 31));
        start = 1'b1;
        tick();
        start = 1'b0;
        m = 45 + $urandom_range(0, 4);
        repeat (m) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_vec_count", 0, 32'(vc0), 10);
        chk("abort_busy", 0, 32'(busy0), 0);
        repeat (3) tick();
        chk("abort_no_done", 0, 32'(done0), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_vec_count", 0, 32'(vc0), 1);
        chk("restart_operands", 0, 32'({a0, b0, c0}), 0);
        chk("restart_vec_valid", 0, 32'(vv0), 1);
        run_cycles(330, 1'b0);

        // Reset pulse while the WIDTH=2 instance is settling.
        op_sel = 5'($urandom_range(0, 31));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (320 + $urandom_range(0, 4)) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 0, 32'(busy0), 0);
        chk("rst_vec_count", 0, 32'(vc0), 0);
        chk("rst_result", 0, 32'(res0), 0);
        run_cycles(8, 1'b0);

        // Randomly timed aborts with random operators.
        for (int r = 0; r < 4; r++) begin
            op_sel = 5'($urandom_range(0, 31));
            start = 1'b1;
            tick();
            start = 1'b0;
            run_cycles($urandom_range(1, 340), 1'b1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            run_cycles(335, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
